// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch-push, execute-resolve and table-update signals
// of the branch resolver. master = fetch/execute/table side, slave = resolver.
`timescale 1ns/1ps

interface branch_resolver_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // fetch push channel
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic [15:0]      pred_target;
    logic [15:0]      pred_fallthru;

    // execute resolve channel
    logic             res_valid;
    logic             res_taken;
    logic [15:0]      res_target;

    // redirect and table update
    logic             mispredict;
    logic [15:0]      redirect_pc;
    logic             upd_load;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_branched;

    // status
    logic [CNT_W-1:0] outstanding;
    logic             res_error;

    modport master (
        output pred_valid, pred_idx, pred_taken, pred_target, pred_fallthru,
        output res_valid, res_taken, res_target,
        input  pred_ready, mispredict, redirect_pc,
        input  upd_load, upd_idx, upd_branched, outstanding, res_error
    );

    modport slave (
        input  pred_valid, pred_idx, pred_taken, pred_target, pred_fallthru,
        input  res_valid, res_taken, res_target,
        output pred_ready, mispredict, redirect_pc,
        output upd_load, upd_idx, upd_branched, outstanding, res_error
    );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of in-flight branch predictions. The oldest
// record is compared with the execute outcome; a wrong prediction raises a
// redirect and squashes every younger record. Every resolution writes the
// outcome back to the 2-bit branch history table.
// Optional: define BRANCH_RESOLVER_STATS_EN for saturating resolve/mispredict
// counters (stat_resolved, stat_mispredict).
`timescale 1ns/1ps

module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    branch_resolver_if.slave bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]      stat_resolved,
    output logic [15:0]      stat_mispredict
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [15:0]      target;
        logic [15:0]      fallthru;
    } rec_t;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    rec_t             head_rec;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             mis;
    logic [15:0]      fix_pc;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head_rec = mem[head];
    assign pop      = bus.res_valid && !empty;
    // a push alongside a mispredict is younger than the bad branch: drop it
    assign push     = bus.pred_valid && !full && !mis;

    assign bus.pred_ready  = !full;
    assign bus.outstanding = count;

    // compare the outcome with the oldest record
    always_comb begin
        mis    = 1'b0;
        fix_pc = head_rec.fallthru;
        if (pop) begin
            if (bus.res_taken != head_rec.taken)
                mis = 1'b1;
            else if (bus.res_taken && (bus.res_target != head_rec.target))
                mis = 1'b1;
            fix_pc = bus.res_taken ? bus.res_target : head_rec.fallthru;
        end
    end

    // record storage; contents are meaningless outside head..tail, so no reset
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{idx:      bus.pred_idx,
                           taken:    bus.pred_taken,
                           target:   bus.pred_target,
                           fallthru: bus.pred_fallthru};
    end

    // pointers and occupancy; a mispredict empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // registered redirect, table update and error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mispredict   <= 1'b0;
            bus.redirect_pc  <= '0;
            bus.upd_load     <= 1'b0;
            bus.upd_idx      <= '0;
            bus.upd_branched <= 1'b0;
            bus.res_error    <= 1'b0;
        end else begin
            bus.mispredict <= mis;
            bus.upd_load   <= pop;
            bus.res_error  <= bus.res_valid && empty;
            if (mis)
                bus.redirect_pc <= fix_pc;
            if (pop) begin
                bus.upd_idx      <= head_rec.idx;
                bus.upd_branched <= bus.res_taken;
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    // saturating resolve / mispredict counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (pop && (stat_resolved != 16'hFFFF))
                stat_resolved <= stat_resolved + 16'd1;
            if (mis && (stat_mispredict != 16'hFFFF))
                stat_mispredict <= stat_mispredict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vector table, randomized run against a
// queue-based reference model, and an asynchronous mid-stream reset.
`timescale 1ns/1ps

module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int IDX_W = 3;

    logic clk;
    logic reset_n;

    branch_resolver_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus();

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredict;
`endif

    branch_resolver #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    // one cycle: inputs already driven, advance past the edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int pv, input int pidx, input int pt, input int ptgt,
                         input int pft, input int rv, input int rt, input int rtgt);
        bus.pred_valid    = pv[0];
        bus.pred_idx      = IDX_W'(pidx);
        bus.pred_taken    = pt[0];
        bus.pred_target   = 16'(ptgt);
        bus.pred_fallthru = 16'(pft);
        bus.res_valid     = rv[0];
        bus.res_taken     = rt[0];
        bus.res_target    = 16'(rtgt);
    endtask

    task automatic chk_all(input string tag, input int mis, input int redir, input int load,
                           input int idx, input int br, input int outs, input int rdy,
                           input int err);
        chk({tag, " mispredict"},   32'(bus.mispredict),   32'(mis));
        chk({tag, " redirect_pc"},  32'(bus.redirect_pc),  32'(redir));
        chk({tag, " upd_load"},     32'(bus.upd_load),     32'(load));
        chk({tag, " upd_idx"},      32'(bus.upd_idx),      32'(idx));
        chk({tag, " upd_branched"}, 32'(bus.upd_branched), 32'(br));
        chk({tag, " outstanding"},  32'(bus.outstanding),  32'(outs));
        chk({tag, " pred_ready"},   32'(bus.pred_ready),   32'(rdy));
        chk({tag, " res_error"},    32'(bus.res_error),    32'(err));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int pv, pidx, pt, ptgt, pft, rv, rt, rtgt;
        int mis, redir, load, idx, br, outs, rdy, err;
    } vec_t;

    function automatic vec_t mk(input int pv, input int pidx, input int pt, input int ptgt,
                                input int pft, input int rv, input int rt, input int rtgt,
                                input int mis, input int redir, input int load, input int idx,
                                input int br, input int outs, input int rdy, input int err);
        vec_t v;
        v.pv = pv; v.pidx = pidx; v.pt = pt; v.ptgt = ptgt; v.pft = pft;
        v.rv = rv; v.rt = rt; v.rtgt = rtgt;
        v.mis = mis; v.redir = redir; v.load = load; v.idx = idx;
        v.br = br; v.outs = outs; v.rdy = rdy; v.err = err;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        int t;
        int tgt;
        int ft;
    } rec_t;

    rec_t q[$];
    int   m_redir, m_idx, m_br;

    initial begin
        int pv, pidx, pt, ptgt, pft, rv, rt, rtgt;
        int e_mis, e_load, e_err;
        bit pop, push;
        rec_t h;

        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();

        //           push: v idx t target    fallthru  res: v t target    expected: mis redir    ld idx br out rdy err
        tbl.push_back(mk(1, 3, 1, 'h0040, 'h0012, 0, 0, 0,         0, 'h0000, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 1, 'h0040,    0, 'h0000, 1, 3, 1, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0,      'h0020, 0, 0, 0,         0, 'h0000, 0, 3, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 1, 'h0100,    1, 'h0100, 1, 5, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0,         0, 'h0100, 0, 5, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'h0A00, 'h0A02, 0, 0, 0,         0, 'h0100, 0, 5, 1, 1, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0,      'h0B02, 0, 0, 0,         0, 'h0100, 0, 5, 1, 2, 1, 0));
        tbl.push_back(mk(1, 4, 1, 'h0C00, 'h0C02, 0, 0, 0,         0, 'h0100, 0, 5, 1, 3, 1, 0));
        tbl.push_back(mk(1, 6, 0, 0,      'h0D02, 0, 0, 0,         0, 'h0100, 0, 5, 1, 4, 0, 0));
        tbl.push_back(mk(1, 7, 1, 'h0E00, 'h0E02, 0, 0, 0,         0, 'h0100, 0, 5, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 1, 'h0A00,    0, 'h0100, 1, 1, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 0, 0,         0, 'h0100, 1, 2, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 1, 'h0C00,    0, 'h0100, 1, 4, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 0, 0,         0, 'h0100, 1, 6, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 0, 0,         0, 'h0100, 0, 6, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0,         0, 'h0100, 0, 6, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2, 1, 'h0300, 'h0032, 0, 0, 0,         0, 'h0100, 0, 6, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0,      'h0042, 0, 0, 0,         0, 'h0100, 0, 6, 0, 2, 1, 0));
        tbl.push_back(mk(1, 4, 1, 'h0500, 'h0052, 0, 0, 0,         0, 'h0100, 0, 6, 0, 3, 1, 0));
        tbl.push_back(mk(1, 5, 1, 'h0550, 'h0552, 1, 0, 0,         1, 'h0032, 1, 2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0,         0, 'h0032, 0, 2, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 'h0600, 'h0602, 0, 0, 0,         0, 'h0032, 0, 2, 0, 1, 1, 0));
        tbl.push_back(mk(1, 7, 0, 0,      'h0702, 1, 1, 'h0600,    0, 'h0032, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 0, 0,         0, 'h0032, 1, 7, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 'h0800, 'h0802, 0, 0, 0,         0, 'h0032, 0, 7, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0,      1, 1, 'h0900,    1, 'h0900, 1, 0, 1, 0, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].pidx, tbl[i].pt, tbl[i].ptgt, tbl[i].pft,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].mis, tbl[i].redir, tbl[i].load,
                    tbl[i].idx, tbl[i].br, tbl[i].outs, tbl[i].rdy, tbl[i].err);
        end

        // ---------------- randomized run vs. queue model ----------------
        do_reset();
        q.delete();
        m_redir = 0; m_idx = 0; m_br = 0;
        for (int c = 0; c < 600; c++) begin
            pv   = (($urandom % 3) != 0) ? 1 : 0;
            pidx = int'($urandom % 8);
            pt   = int'($urandom % 2);
            ptgt = 'h0100 * int'($urandom_range(1, 3));
            pft  = int'($urandom % 'h10000);
            rv   = int'($urandom % 2);
            if (q.size() > 0 && ($urandom % 10) < 7) begin
                rt   = q[0].t;
                rtgt = (rt != 0) ? q[0].tgt : int'($urandom % 'h10000);
            end else begin
                rt   = int'($urandom % 2);
                rtgt = 'h0100 * int'($urandom_range(1, 3));
            end
            drive(pv, pidx, pt, ptgt, pft, rv, rt, rtgt);

            pop   = (rv != 0) && (q.size() > 0);
            e_err = (rv != 0 && q.size() == 0) ? 1 : 0;
            e_mis = 0;
            if (pop) begin
                h = q[0];
                if (rt != h.t || (rt != 0 && rtgt != h.tgt)) e_mis = 1;
                if (e_mis != 0) m_redir = (rt != 0) ? rtgt : h.ft;
                m_idx = h.idx;
                m_br  = rt;
            end
            e_load = pop ? 1 : 0;
            push   = (pv != 0) && (q.size() < DEPTH) && (e_mis == 0);
            if (e_mis != 0) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{idx: pidx, t: pt, tgt: ptgt, ft: pft});
            end

            step();
            chk_all($sformatf("rnd%0d", c), e_mis, m_redir, e_load, m_idx, m_br,
                    q.size(), (q.size() < DEPTH) ? 1 : 0, e_err);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        do_reset();
        drive(1, 1, 1, 'h0010, 'h0002, 0, 0, 0);      step();
        drive(1, 2, 0, 0, 'h0004, 0, 0, 0);           step();
        drive(0, 0, 0, 0, 0, 1, 1, 'h0010);           step();   // correct
        drive(0, 0, 0, 0, 0, 1, 1, 'h0020);           step();   // mispredict
        chk("ar mispredict", 32'(bus.mispredict), 32'd1);
        chk("ar redirect", 32'(bus.redirect_pc), 32'h0020);
        drive(1, 3, 1, 'h0030, 'h0006, 0, 0, 0);      step();
        drive(1, 4, 0, 0, 'h0008, 0, 0, 0);           step();
        drive(1, 5, 1, 'h0050, 'h000A, 1, 1, 'h0030); step();   // correct + push
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("ar before", 0, 'h0020, 1, 3, 1, 2, 1, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_resolved before", 32'(stat_resolved), 32'd3);
        chk("stat_mispredict before", 32'(stat_mispredict), 32'd1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("ar async", 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_resolved after", 32'(stat_resolved), 32'd0);
        chk("stat_mispredict after", 32'(stat_mispredict), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        // queue must really be empty: resolving now is an error, not a pop
        drive(0, 0, 0, 0, 0, 1, 1, 'h0050);
        step();
        chk_all("ar post", 0, 0, 0, 0, 0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
